// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer -- multi-cycle control sequencer for the eightbit CPU.
// Walks each instruction through fetch, PC increment, decode and execute,
// and drives the register/ALU/memory control strobes of the datapath.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   instruction           IR contents; opcode = instruction[INSTR_W-1 -: 4]
//   overflow, zero        ALU flags used by JMO / JMZ
//   mem_ready             memory completes the access this cycle
//   run                   level: free-run while 1
//   step                  pulse: run a single instruction from IDLE
//   ir_low .. alu_mem     register operations (reg_op_t encoding)
//   overflow_read .. mem_enable   single-bit strobes
//   alu_mem_mode          memory-ALU mode (memalu_op_t encoding)
//   halted                sequencer is in IDLE
//   fault                 sticky memory-timeout / illegal-opcode indication
//
// Optional build macro CTRL_TRACE_EN adds the outputs retired[CNT_W-1:0]
// (completed-instruction counter) and state_dbg[4:0] (current state code).
//
// State table
//   IDLE     | halted, waiting for run or step
//   FETCH_A  | PC onto address bus
//   FETCH_B  | memory read of the instruction, waits for mem_ready
//   FETCH_C  | instruction latched into IR
//   INCPC_A  | PC into memory-ALU for increment
//   INCPC_B  | incremented PC written back, opcode decoded
//   ASTL..MSTH | single-cycle register transfers
//   OPER_A/B | ALU operation and flag capture
//   JMP_A/B  | PC plus offset through memory-ALU
//   LOD_A-D  | memory load, LOD_C waits for mem_ready
//   STO_A-D  | memory store, STO_D waits for mem_ready
//   SWP_A-C  | accumulator/swap-register exchange via temp
//   MADD_A/B | memory pointer add through memory-ALU
//   FAULT    | sticky fault, left only by reset

package ctrl_sequencer_pkg;
    typedef enum logic [1:0] {
        REG_OP_NONE  = 2'd0,
        REG_OP_READ  = 2'd1,
        REG_OP_WRITE = 2'd2
    } reg_op_t;

    typedef enum logic [1:0] {
        MEMALU_OP_ADD    = 2'd0,
        MEMALU_OP_INCR   = 2'd1,
        MEMALU_OP_OFFSET = 2'd2
    } memalu_op_t;
endpackage

module ctrl_sequencer #(
    parameter int unsigned INSTR_W       = 4,
    parameter int unsigned MEM_TIMEOUT   = 8,
    parameter bit          ILLEGAL_FAULT = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               overflow,
    input  logic               zero,
    input  logic               mem_ready,
    input  logic               run,
    input  logic               step,
    output logic [1:0]         ir_low,
    output logic [1:0]         ir_high,
    output logic [1:0]         acc_low,
    output logic [1:0]         acc_high,
    output logic [1:0]         temp_register,
    output logic [1:0]         pc,
    output logic [1:0]         mp16,
    output logic [1:0]         swap_register,
    output logic [1:0]         alu_data,
    output logic [1:0]         alu_mem,
    output logic               overflow_read,
    output logic               zero_read,
    output logic               mp8_low,
    output logic               mp8_high,
    output logic               address_read,
    output logic               data_in,
    output logic               data_out,
    output logic               mem_enable,
    output logic [1:0]         alu_mem_mode,
    output logic               halted,
    output logic               fault
`ifdef CTRL_TRACE_EN
    ,
    output logic [CNT_W-1:0]   retired,
    output logic [4:0]         state_dbg
`endif
);
    import ctrl_sequencer_pkg::*;

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH_A, S_FETCH_B, S_FETCH_C, S_INCPC_A, S_INCPC_B,
        S_ASTL, S_ASTH, S_MSTL, S_MSTH, S_OPER_A, S_OPER_B,
        S_JMP_A, S_JMP_B, S_LOD_A, S_LOD_B, S_LOD_C, S_LOD_D,
        S_STO_A, S_STO_B, S_STO_C, S_STO_D, S_SWP_A, S_SWP_B, S_SWP_C,
        S_MADD_A, S_MADD_B, S_FAULT
    } state_t;

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    logic [3:0]        opcode;
    logic              boundary;
    state_t            end_state;

    assign opcode    = instruction[INSTR_W-1 -: 4];
    assign end_state = run ? S_FETCH_A : S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        boundary      = 1'b0;
        case (state)
            S_IDLE:    if (run || step) state_next = S_FETCH_A;
            S_FETCH_A: state_next = S_FETCH_B;
            S_FETCH_B: begin
                // A ready access in the timeout cycle still completes.
                if (mem_ready) begin
                    state_next    = S_FETCH_C;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next    = S_FAULT;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            S_FETCH_C: state_next = S_INCPC_A;
            S_INCPC_A: state_next = S_INCPC_B;
            S_INCPC_B: begin
                case (opcode)
                    4'd0:  state_next = S_ASTL;
                    4'd1:  state_next = S_ASTH;
                    4'd2:  state_next = S_MSTL;
                    4'd3:  state_next = S_MSTH;
                    4'd4:  state_next = S_OPER_A;
                    4'd6:  state_next = S_JMP_A;
                    4'd7: begin
                        if (zero) state_next = S_JMP_A;
                        else begin
                            state_next = end_state;
                            boundary   = 1'b1;
                        end
                    end
                    4'd8: begin
                        if (overflow) state_next = S_JMP_A;
                        else begin
                            state_next = end_state;
                            boundary   = 1'b1;
                        end
                    end
                    4'd9:  state_next = S_LOD_A;
                    4'd10: state_next = S_STO_A;
                    4'd11: state_next = S_SWP_A;
                    4'd12: state_next = S_MADD_A;
                    default: begin
                        if (ILLEGAL_FAULT) state_next = S_FAULT;
                        else begin
                            state_next = end_state;
                            boundary   = 1'b1;
                        end
                    end
                endcase
            end
            S_OPER_A: state_next = S_OPER_B;
            S_JMP_A:  state_next = S_JMP_B;
            S_LOD_A:  state_next = S_LOD_B;
            S_LOD_B:  state_next = S_LOD_C;
            S_LOD_C: begin
                if (mem_ready) begin
                    state_next    = S_LOD_D;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next    = S_FAULT;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            S_STO_A: state_next = S_STO_B;
            S_STO_B: state_next = S_STO_C;
            S_STO_C: state_next = S_STO_D;
            S_STO_D: begin
                if (mem_ready) begin
                    state_next    = end_state;
                    boundary      = 1'b1;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next    = S_FAULT;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            S_SWP_A:  state_next = S_SWP_B;
            S_SWP_B:  state_next = S_SWP_C;
            S_MADD_A: state_next = S_MADD_B;
            S_ASTL, S_ASTH, S_MSTL, S_MSTH, S_OPER_B, S_JMP_B,
            S_LOD_D, S_SWP_C, S_MADD_B: begin
                state_next = end_state;
                boundary   = 1'b1;
            end
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ir_low        = REG_OP_NONE;
        ir_high       = REG_OP_NONE;
        acc_low       = REG_OP_NONE;
        acc_high      = REG_OP_NONE;
        temp_register = REG_OP_NONE;
        pc            = REG_OP_NONE;
        mp16          = REG_OP_NONE;
        swap_register = REG_OP_NONE;
        alu_data      = REG_OP_NONE;
        alu_mem       = REG_OP_NONE;
        overflow_read = 1'b0;
        zero_read     = 1'b0;
        mp8_low       = 1'b0;
        mp8_high      = 1'b0;
        address_read  = 1'b0;
        data_in       = 1'b0;
        data_out      = 1'b0;
        mem_enable    = 1'b0;
        alu_mem_mode  = MEMALU_OP_ADD;
        halted        = (state == S_IDLE);
        fault         = (state == S_FAULT);
        case (state)
            S_FETCH_A: begin pc = REG_OP_WRITE; address_read = 1'b1; end
            S_FETCH_B: begin data_in = 1'b1; mem_enable = 1'b1; end
            S_FETCH_C: begin
                data_in    = 1'b1;
                mem_enable = 1'b1;
                ir_low     = REG_OP_READ;
                ir_high    = REG_OP_READ;
            end
            S_INCPC_A: begin
                pc = REG_OP_WRITE; alu_mem = REG_OP_READ; alu_mem_mode = MEMALU_OP_INCR;
            end
            S_INCPC_B: begin
                alu_mem = REG_OP_WRITE; pc = REG_OP_READ; alu_mem_mode = MEMALU_OP_INCR;
            end
            S_ASTL: begin acc_low = REG_OP_READ; mp8_low = 1'b1; end
            S_ASTH: begin acc_high = REG_OP_READ; mp8_high = 1'b1; end
            S_MSTL: begin mp16 = REG_OP_READ; mp8_low = 1'b1; end
            S_MSTH: begin mp16 = REG_OP_READ; mp8_high = 1'b1; end
            S_OPER_A: begin
                acc_low = REG_OP_WRITE; acc_high = REG_OP_WRITE; alu_data = REG_OP_READ;
            end
            S_OPER_B: begin
                alu_data      = REG_OP_WRITE;
                acc_low       = REG_OP_READ;
                acc_high      = REG_OP_READ;
                overflow_read = 1'b1;
                zero_read     = 1'b1;
            end
            S_JMP_A: begin
                pc = REG_OP_WRITE; alu_mem = REG_OP_READ; alu_mem_mode = MEMALU_OP_OFFSET;
            end
            S_JMP_B: begin
                alu_mem = REG_OP_WRITE; pc = REG_OP_READ; alu_mem_mode = MEMALU_OP_OFFSET;
            end
            S_LOD_A, S_LOD_B, S_STO_A: begin mp16 = REG_OP_WRITE; address_read = 1'b1; end
            S_LOD_C: begin data_in = 1'b1; mem_enable = 1'b1; end
            S_LOD_D: begin data_in = 1'b1; acc_low = REG_OP_READ; end
            S_STO_B: begin acc_low = REG_OP_WRITE; temp_register = REG_OP_READ; end
            S_STO_C: begin temp_register = REG_OP_WRITE; data_out = 1'b1; end
            S_STO_D: begin
                temp_register = REG_OP_WRITE; data_out = 1'b1; mem_enable = 1'b1;
            end
            // Exchange acc_low and swap_register through the temp register.
            S_SWP_A: begin acc_low = REG_OP_WRITE; temp_register = REG_OP_READ; end
            S_SWP_B: begin swap_register = REG_OP_WRITE; acc_low = REG_OP_READ; end
            S_SWP_C: begin temp_register = REG_OP_WRITE; swap_register = REG_OP_READ; end
            S_MADD_A: begin mp16 = REG_OP_WRITE; alu_mem = REG_OP_READ; end
            S_MADD_B: begin alu_mem = REG_OP_WRITE; mp16 = REG_OP_READ; end
            default: ;
        endcase
    end

`ifdef CTRL_TRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired <= '0;
        else if (boundary) retired <= retired + 1'b1;
    end

    assign state_dbg = state;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed scenarios plus randomized
// instruction streams checked against a cycle-timeline model of each
// instruction (length, memory-enable windows, boundary behaviour).
module tb_ctrl_sequencer;
    import ctrl_sequencer_pkg::*;

    localparam int INSTR_W     = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 16;

    localparam logic [1:0] OP_NONE  = REG_OP_NONE;
    localparam logic [1:0] OP_RD    = REG_OP_READ;
    localparam logic [1:0] OP_WR    = REG_OP_WRITE;
    localparam logic [1:0] M_ADD    = MEMALU_OP_ADD;
    localparam logic [1:0] M_INCR   = MEMALU_OP_INCR;
    localparam logic [1:0] M_OFFSET = MEMALU_OP_OFFSET;

    logic clk, rst_n;
    logic [INSTR_W-1:0] instruction;
    logic overflow, zero, mem_ready, run, step;
    logic [1:0] ir_low, ir_high, acc_low, acc_high, temp_register, pc, mp16;
    logic [1:0] swap_register, alu_data, alu_mem, alu_mem_mode;
    logic overflow_read, zero_read, mp8_low, mp8_high, address_read;
    logic data_in, data_out, mem_enable, halted, fault;
`ifdef CTRL_TRACE_EN
    logic [CNT_W-1:0] retired;
    logic [4:0]       state_dbg;
`endif

    ctrl_sequencer #(
        .INSTR_W(INSTR_W), .MEM_TIMEOUT(MEM_TIMEOUT), .ILLEGAL_FAULT(1'b1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .overflow(overflow),
        .zero(zero), .mem_ready(mem_ready), .run(run), .step(step),
        .ir_low(ir_low), .ir_high(ir_high), .acc_low(acc_low), .acc_high(acc_high),
        .temp_register(temp_register), .pc(pc), .mp16(mp16),
        .swap_register(swap_register), .alu_data(alu_data), .alu_mem(alu_mem),
        .overflow_read(overflow_read), .zero_read(zero_read), .mp8_low(mp8_low),
        .mp8_high(mp8_high), .address_read(address_read), .data_in(data_in),
        .data_out(data_out), .mem_enable(mem_enable), .alu_mem_mode(alu_mem_mode),
        .halted(halted), .fault(fault)
`ifdef CTRL_TRACE_EN
        , .retired(retired), .state_dbg(state_dbg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int unsigned ret_model = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] out_sig();
        return {ir_low, ir_high, acc_low, acc_high, temp_register, pc, mp16,
                swap_register, alu_data, alu_mem,
                overflow_read, zero_read, mp8_low, mp8_high,
                address_read, data_in, data_out, mem_enable,
                alu_mem_mode, halted, fault};
    endfunction

    function automatic logic [31:0] default_sig(input bit h, input bit f);
        logic [19:0] ops;
        ops = {10{OP_NONE}};
        return {ops, 8'h00, M_ADD, h, f};
    endfunction

    // Cycles per instruction with memory always ready.
    function automatic int base_len(input int op, input bit z, input bit o);
        case (op)
            0, 1, 2, 3:  return 6;
            4, 6, 12:    return 7;
            7:           return z ? 7 : 5;
            8:           return o ? 7 : 5;
            9, 10:       return 9;
            11:          return 8;
            default:     return 5;
        endcase
    endfunction

    function automatic bit jump_taken(input int op, input bit z, input bit o);
        return (op == 6) || (op == 7 && z) || (op == 8 && o);
    endfunction

    task automatic set_instr(input int op);
        logic [INSTR_W-1:0] iv;
        logic [3:0] opc;
        iv  = INSTR_W'($urandom);
        opc = op[3:0];
        iv[INSTR_W-1 -: 4] = opc;
        instruction = iv;
    endtask

    task automatic check_retired();
`ifdef CTRL_TRACE_EN
        check("retired", 32'(retired), 32'(ret_model[CNT_W-1:0]));
`endif
    endtask

    // Runs one instruction starting with the DUT in FETCH_A.
    // sf/sm are stall cycles in the fetch and data memory waits.
    task automatic run_instr(input int op, input bit z, input bit o,
                             input int sf, input int sm, input bit keep_run);
        int len, m, acc_rd, n_off, n_incr;
        bit is_mem, en_exp;
        set_instr(op);
        zero = z;
        overflow = o;
        is_mem = (op == 9) || (op == 10);
        if (!is_mem) sm = 0;
        m = ((op == 9) ? 7 : 8) + sf;
        len = base_len(op, z, o) + sf + sm;
        acc_rd = 0; n_off = 0; n_incr = 0;
        for (int c = 0; c < len; c++) begin
            mem_ready = !((c >= 1 && c <= sf) || (is_mem && c >= m && c < m + sm));
            if (c == 0) check("fetch_a", {pc, address_read}, {OP_WR, 1'b1});
            en_exp = (c >= 1 && c <= 2 + sf) || (is_mem && c >= m && c <= m + sm);
            check("mem_enable", 32'(mem_enable), 32'(en_exp));
            check("busy_flags", {halted, fault}, 2'b00);
            if (op == 0 && c == len - 1) check("astl_acc_low", 32'(acc_low), 32'(OP_RD));
            if (acc_low == OP_RD || acc_high == OP_RD) acc_rd++;
            if (alu_mem_mode == M_OFFSET) n_off++;
            if (alu_mem_mode == M_INCR) n_incr++;
            if (c == 1) run = keep_run;
            tick();
        end
        ret_model++;
        if (op == 9) check("lod_acc_read_once", 32'(acc_rd), 32'd1);
        check("incr_cycles", 32'(n_incr), 32'd2);
        check("offset_cycles", 32'(n_off), jump_taken(op, z, o) ? 32'd2 : 32'd0);
        if (keep_run)
            check("next_fetch", {pc, address_read, halted}, {OP_WR, 1'b1, 1'b0});
        else
            check("halt_after", {halted, fault}, 2'b10);
        check_retired();
    endtask

    task automatic start_run();
        run = 1'b1;
        mem_ready = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", out_sig(), default_sig(1'b1, 1'b0));
        ret_model = 0;
        run = 1'b0; step = 1'b0; mem_ready = 1'b1;
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        check_retired();
    endtask

    initial begin
        int legal[12] = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12};
        int op, sf, sm;
        bit keep;
        rst_n = 1'b0; run = 1'b0; step = 1'b0; mem_ready = 1'b1;
        zero = 1'b0; overflow = 1'b0; instruction = '0;
        #2;
        check("reset_outputs", out_sig(), default_sig(1'b1, 1'b0));
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        check("idle_hold", out_sig(), default_sig(1'b1, 1'b0));
        check_retired();

        // Opcode 0 with run held, then JMZ not taken / taken.
        start_run();
        run_instr(0, 1'b0, 1'b0, 0, 0, 1'b1);
        run_instr(7, 1'b0, 1'b0, 0, 0, 1'b1);
        run_instr(7, 1'b1, 1'b0, 0, 0, 1'b1);
        // LOD with three stalled cycles in LOD_C, STO with a boundary-length stall.
        run_instr(9, 1'b0, 1'b0, 0, 3, 1'b1);
        run_instr(10, 1'b0, 1'b0, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0);

        // Single step of OPER, with run low.
        step = 1'b1;
        tick();
        step = 1'b0;
        run_instr(4, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (3) tick();
        check("step_stays_idle", {halted, fault}, 2'b10);

        // Randomized instruction stream.
        start_run();
        for (int i = 0; i < 40; i++) begin
            op = legal[$urandom_range(0, 11)];
            sf = ($urandom_range(0, 4) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
            sm = ($urandom_range(0, 4) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
            keep = (i != 39) && ($urandom_range(0, 3) != 0);
            run_instr(op, 1'($urandom), 1'($urandom), sf, sm, keep);
            if (!keep && i != 39) start_run();
        end

        // Reset in the middle of a load: outputs drop immediately.
        start_run();
        set_instr(9);
        repeat (6) tick();
        do_reset();
        check("post_reset_idle", out_sig(), default_sig(1'b1, 1'b0));

        // Fetch timeout: memory never ready.
        set_instr(0);
        run = 1'b1;
        mem_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            check("stall_no_fault", {mem_enable, fault}, 2'b10);
            tick();
        end
        check("timeout_fault", out_sig(), default_sig(1'b0, 1'b1));
        run = 1'b0; step = 1'b1; mem_ready = 1'b1;
        tick();
        step = 1'b0; run = 1'b1;
        repeat (3) tick();
        check("fault_sticky", out_sig(), default_sig(1'b0, 1'b1));
        do_reset();

        // Illegal opcodes fault right after INCPC_B.
        for (int j = 0; j < 2; j++) begin
            set_instr(j == 0 ? 13 : 5);
            start_run();
            repeat (4) tick();
            check("illegal_pre", {alu_mem, fault}, {OP_WR, 1'b0});
            tick();
            check("illegal_fault", out_sig(), default_sig(1'b0, 1'b1));
            do_reset();
            check("illegal_cleared", {halted, fault}, 2'b10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
